uart_rx_oversampled: RTL

Byte-level UART receiver for the 8N1 serial link: the receive-side counterpart of the team's `uart_tx`. It synchronizes the asynchronous `uart_rxd_in` pin, validates the start bit, and takes a 3-sample majority vote at each bit centre. It delivers each received byte to the fabric through a one-entry valid/ready holding register, with pulsed framing-error and overrun flags. It sits between the board RX pin and the host-command parser.

---
 rtl/uart_rx_oversampled.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit validation, 3-sample majority
// vote at each bit centre and a one-entry valid/ready holding register.
module uart_rx_oversampled #(
   parameter int CLOCKS_PER_BAUD = 33
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       uart_rxd_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   input  logic       ready_in,
   output logic       frame_err_out,
   output logic       overrun_out,
   output logic       busy_out
);

   localparam int CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
   localparam int M  = CLOCKS_PER_BAUD / 2;
   localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(M);
   localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BAUD - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      bit_idx_reg, bit_idx_next;
   logic [7:0]      shift_reg, shift_next;
   logic            sync1_reg, sync2_reg, prev_reg;
   logic            samp0_reg, samp1_reg;
   logic [7:0]      data_reg;
   logic            valid_reg, frame_err_reg, overrun_reg, busy_reg;

   logic            majority, decide, wrap;
   logic            frame_ok, frame_bad;

   // Third vote is the live synchronized sample on the decision edge.
   assign majority = (samp0_reg & samp1_reg) | (samp0_reg & sync2_reg) | (samp1_reg & sync2_reg);
   assign decide   = (cnt_reg == CNT_DEC);
   assign wrap     = (cnt_reg == CNT_LAST);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = wrap ? '0 : cnt_reg + CW'(1);
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      frame_ok     = 1'b0;
      frame_bad    = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            // Falling edge only, so a line stuck low cannot retrigger.
            if (prev_reg && !sync2_reg) state_next = START;
         end
         START: begin
            if (decide && majority) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (wrap) begin
               state_next   = DATA;
               bit_idx_next = 3'd0;
            end
         end
         DATA: begin
            if (decide) shift_next = {majority, shift_reg[7:1]};
            if (wrap) begin
               if (bit_idx_reg == 3'd7) state_next = STOP;
               else bit_idx_next = bit_idx_reg + 3'd1;
            end
         end
         STOP: begin
            // Leave early so a start edge right after the stop bit is caught.
            if (decide) begin
               state_next = IDLE;
               cnt_next   = '0;
               frame_ok   = majority;
               frame_bad  = !majority;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= 3'd0;
         shift_reg     <= 8'h00;
         sync1_reg     <= 1'b1;
         sync2_reg     <= 1'b1;
         prev_reg      <= 1'b1;
         samp0_reg     <= 1'b1;
         samp1_reg     <= 1'b1;
         data_reg      <= 8'h00;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         sync1_reg   <= uart_rxd_in;
         sync2_reg   <= sync1_reg;
         prev_reg    <= sync2_reg;
         if (cnt_reg == CNT_S0) samp0_reg <= sync2_reg;
         if (cnt_reg == CNT_S1) samp1_reg <= sync2_reg;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         busy_reg    <= (state_next != IDLE);

         frame_err_reg <= frame_bad;
         overrun_reg   <= 1'b0;
         if (frame_ok) begin
            if (!valid_reg || ready_in) begin
               data_reg  <= shift_reg;
               valid_reg <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (valid_reg && ready_in) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign data_out      = data_reg;
   assign valid_out     = valid_reg;
   assign frame_err_out = frame_err_reg;
   assign overrun_out   = overrun_reg;
   assign busy_out      = busy_reg;

endmodule
